// File: rtl/gf256_pkg.sv
// gf256_pkg: shared AES-field types, constants and the GF(2^8) multiply function.
package gf256_pkg;

    typedef logic [7:0] gf_byte_t;

    localparam gf_byte_t GF_POLY_LO = 8'h1B;

    typedef enum logic {EMPTY, FULL} out_state_t;

    // Shift-and-add: accumulate t for each set bit of b, then xtime t.
    function automatic gf_byte_t gf_mul(gf_byte_t a, gf_byte_t b, gf_byte_t poly_lo);
        gf_byte_t p = '0;
        gf_byte_t t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (poly_lo & {8{t[7]}});
        end
        return p;
    endfunction

endpackage

// File: rtl/gf256_mul_arbiter_if.sv
// gf256_mul_arbiter_if: requester and response bundle for the shared GF(2^8) multiplier.
interface gf256_mul_arbiter_if import gf256_pkg::*; #(parameter int NREQ = 4);
    localparam int IDW = $clog2(NREQ);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    gf_byte_t          rsp_data;
    logic [IDW-1:0]    rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/gf256_mul_arbiter_rr_pick.sv
// rr_pick: N-way round-robin priority picker; first valid at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    // Rotating the doubled vector puts ptr at bit 0, so the lowest set bit is the winner.
    assign rot = N'({valid, valid} >> ptr);
    assign any = |valid;
    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = IW'(sum >= (IW+1)'(N) ? sum - (IW+1)'(N) : sum);
    assign grant = any ? (N'(1) << idx) : '0;

    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) off = IW'(k);
    end
endmodule

// File: rtl/gf256_mul_arbiter.sv
// gf256_mul_arbiter: round-robin sharing of one GF(2^8) multiplier with a one-entry tagged output register.
// Define GF_ARB_STATS_EN to add the 16-bit wrapping grant_cnt handshake counter.
module gf256_mul_arbiter import gf256_pkg::*; #(
    parameter int       NREQ    = 4,
    parameter gf_byte_t POLY_LO = GF_POLY_LO
) (
    input logic clk,
    input logic rst,
    gf256_mul_arbiter_if.slave bus
`ifdef GF_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt
`endif
);
    localparam int IDW = $clog2(NREQ);

    out_state_t     state, state_nxt;
    logic           accept;
    logic           any;
    logic           hs;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] rr_ptr;
    gf_byte_t       prod;

    rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    assign hs = any & accept;
    assign bus.req_ready = grant & {NREQ{accept}};
    assign prod = gf_mul(bus.req_a[8*idx +: 8], bus.req_b[8*idx +: 8], POLY_LO);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= EMPTY;
        else     state <= state_nxt;

    always_comb
        state_nxt = hs ? FULL : (state == FULL && bus.rsp_ready) ? EMPTY : state;

    always_comb begin
        bus.rsp_valid = (state == FULL);
        accept = (state == EMPTY) | bus.rsp_ready;
    end

    // Data and tag only move on a handshake, so a drain leaves the last product visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_data <= '0;
            bus.rsp_id   <= '0;
            rr_ptr       <= '0;
        end else if (hs) begin
            bus.rsp_data <= prod;
            bus.rsp_id   <= idx;
            rr_ptr       <= (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

`ifdef GF_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)     grant_cnt <= '0;
        else if (hs) grant_cnt <= grant_cnt + 16'd1;
`endif
endmodule
